// File: rtl/pulse_trigger_pkg.sv
// Shared definitions for the pulse trigger path: FIFO word field positions,
// header field positions, channel count, sequencer state encodings and the
// header packing helper. The trigger receiver packs its FIFO words with the
// same offsets.
package pulse_trigger_pkg;

    localparam int NUM_CHAN    = 5;
    localparam int CHAN_IDX_W  = 3;

    // Trigger-info word held in the Pulse Trigger FIFO
    localparam int TS_LSB      = 0;
    localparam int TS_WIDTH    = 44;
    localparam int NUM_LSB     = 44;
    localparam int NUM_WIDTH   = 24;
    localparam int LEN_LSB     = 68;
    localparam int LEN_WIDTH   = 2;

    // Header word sent to the event builder
    localparam int HDR_TS_LSB     = 0;
    localparam int HDR_NUM_LSB    = 44;
    localparam int HDR_LEN_LSB    = 68;
    localparam int HDR_MASK_LSB   = 70;
    localparam int HDR_TOMASK_LSB = 75;
    localparam int HDR_PAD_LSB    = 80;
    localparam int HDR_PAD_WIDTH  = 48;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PICK     = 3'd1,
        REQ      = 3'd2,
        WAIT     = 3'd3,
        SEND_HDR = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

    // Packs the header word; bits above the timeout mask are always zero.
    function automatic logic [127:0] build_header(
        input logic [NUM_CHAN-1:0]  to_mask,
        input logic [NUM_CHAN-1:0]  mask,
        input logic [LEN_WIDTH-1:0] len,
        input logic [NUM_WIDTH-1:0] num,
        input logic [TS_WIDTH-1:0]  ts
    );
        return {{HDR_PAD_WIDTH{1'b0}}, to_mask, mask, len, num, ts};
    endfunction

endpackage

// File: rtl/chan_priority_pick.sv
// Lowest-set-bit encoder: picks the lowest-numbered pending channel.
// 'none' is high when no channel is pending.
module chan_priority_pick
    import pulse_trigger_pkg::*;
(
    input  logic [NUM_CHAN-1:0]   mask,
    output logic [CHAN_IDX_W-1:0] idx,
    output logic                  none
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx  = '0;
        none = (mask == '0);
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CHAN_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pulse_trigger_sequencer.sv
// Consumer side of the Pulse Trigger FIFO. Pops one trigger-info word, asks
// each enabled channel for a readout in ascending order (with a per-channel
// timeout), then hands one header word to the event builder and pulses
// readout_done back to the trigger receiver.
module pulse_trigger_sequencer
    import pulse_trigger_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CHAN-1:0] chan_en,
    input  logic                fifo_valid,
    input  logic [127:0]        fifo_data,
    output logic                fifo_ready,
    output logic [NUM_CHAN-1:0] chan_req,
    input  logic [NUM_CHAN-1:0] chan_done,
    output logic                hdr_valid,
    input  logic                hdr_ready,
    output logic [127:0]        hdr_data,
    output logic                readout_done,
    output logic [2:0]          state,
    output logic [31:0]         timeout_count
);

    localparam logic [15:0] TERM = 16'(TIMEOUT_CYCLES - 1);

    seq_state_t state_q, state_n;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [NUM_WIDTH-1:0]  num_q;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [NUM_CHAN-1:0]   pend_q, pend_n;
    logic [NUM_CHAN-1:0]   mask_q;
    logic [NUM_CHAN-1:0]   to_mask_q, to_mask_n;
    logic [CHAN_IDX_W-1:0] idx_q;
    logic [CHAN_IDX_W-1:0] pick_idx;
    logic                  pick_none;
    logic [NUM_CHAN-1:0]   idx_bit;
    logic [15:0]           tcnt_q;
    logic                  armed_q;

    logic                  pop;
    logic                  enter_hdr;
    logic                  hdr_accept;
    logic                  chan_hit;
    logic                  to_hit;
    logic [127:0]          hdr_n;

    logic [LEN_WIDTH-1:0]  fifo_len;
    logic [NUM_WIDTH-1:0]  fifo_num;
    logic [TS_WIDTH-1:0]   fifo_ts;
    logic                  unused_fifo_bits;

    assign fifo_len         = fifo_data[LEN_LSB +: LEN_WIDTH];
    assign fifo_num         = fifo_data[NUM_LSB +: NUM_WIDTH];
    assign fifo_ts          = fifo_data[TS_LSB +: TS_WIDTH];
    assign unused_fifo_bits = ^fifo_data[127:LEN_LSB+LEN_WIDTH];

    // armed_q keeps fifo_ready low until the first cycle after reset releases
    assign fifo_ready = (state_q == IDLE) && armed_q;
    assign state      = state_q;
    assign idx_bit    = NUM_CHAN'(1) << idx_q;

    chan_priority_pick u_pick (
        .mask (pend_q),
        .idx  (pick_idx),
        .none (pick_none)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic plus the per-cycle strobes and header word for the datapath
    always_comb begin
        state_n    = state_q;
        pend_n     = pend_q;
        to_mask_n  = to_mask_q;
        pop        = 1'b0;
        enter_hdr  = 1'b0;
        hdr_accept = 1'b0;
        chan_hit   = 1'b0;
        to_hit     = 1'b0;
        hdr_n      = '0;

        case (state_q)
            IDLE: begin
                if (fifo_valid && fifo_ready) begin
                    pop       = 1'b1;
                    pend_n    = chan_en;
                    to_mask_n = '0;
                    if (chan_en == '0) begin
                        state_n   = SEND_HDR;
                        enter_hdr = 1'b1;
                    end else begin
                        state_n = PICK;
                    end
                end
            end
            PICK: begin
                if (pick_none) begin
                    state_n   = SEND_HDR;
                    enter_hdr = 1'b1;
                end else begin
                    state_n = REQ;
                end
            end
            REQ: begin
                state_n = WAIT;
            end
            WAIT: begin
                chan_hit = |(chan_done & idx_bit);
                to_hit   = !chan_hit && (tcnt_q == TERM);
                if (chan_hit || to_hit) begin
                    pend_n = pend_q & ~idx_bit;
                    if (to_hit) begin
                        to_mask_n = to_mask_q | idx_bit;
                    end
                    if (pend_n == '0) begin
                        state_n   = SEND_HDR;
                        enter_hdr = 1'b1;
                    end else begin
                        state_n = PICK;
                    end
                end
            end
            SEND_HDR: begin
                if (hdr_ready) begin
                    hdr_accept = 1'b1;
                    state_n    = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_q == IDLE) begin
            hdr_n = build_header('0, '0, fifo_len, fifo_num, fifo_ts);
        end else begin
            hdr_n = build_header(to_mask_n, mask_q, len_q, num_q, ts_q);
        end
    end

    // Event datapath and registered outputs; reset drops any in-flight event
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q       <= 1'b0;
            len_q         <= '0;
            num_q         <= '0;
            ts_q          <= '0;
            pend_q        <= '0;
            mask_q        <= '0;
            to_mask_q     <= '0;
            idx_q         <= '0;
            tcnt_q        <= '0;
            chan_req      <= '0;
            hdr_valid     <= 1'b0;
            hdr_data      <= '0;
            readout_done  <= 1'b0;
            timeout_count <= '0;
        end else begin
            armed_q   <= 1'b1;
            pend_q    <= pend_n;
            to_mask_q <= to_mask_n;

            if (pop) begin
                len_q  <= fifo_len;
                num_q  <= fifo_num;
                ts_q   <= fifo_ts;
                mask_q <= chan_en;
            end

            if (state_q == PICK) begin
                idx_q  <= pick_idx;
                tcnt_q <= '0;
            end else if (state_q == WAIT) begin
                tcnt_q <= tcnt_q + 16'd1;
            end

            if ((state_q == PICK) && !pick_none) begin
                chan_req <= NUM_CHAN'(1) << pick_idx;
            end else begin
                chan_req <= '0;
            end

            if (to_hit && (timeout_count != '1)) begin
                timeout_count <= timeout_count + 32'd1;
            end

            if (enter_hdr) begin
                hdr_valid <= 1'b1;
                hdr_data  <= hdr_n;
            end else if (hdr_accept) begin
                hdr_valid <= 1'b0;
            end

            readout_done <= hdr_accept;
        end
    end

endmodule

// File: tb/tb_pulse_trigger_sequencer.sv
// Directed bench for pulse_trigger_sequencer with a 16-cycle channel timeout.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pulse_trigger_sequencer;

    logic         clk;
    logic         reset;
    logic [4:0]   chan_en;
    logic         fifo_valid;
    logic [127:0] fifo_data;
    logic         fifo_ready;
    logic [4:0]   chan_req;
    logic [4:0]   chan_done;
    logic         hdr_valid;
    logic         hdr_ready;
    logic [127:0] hdr_data;
    logic         readout_done;
    logic [2:0]   state;
    logic [31:0]  timeout_count;

    int compared   = 0;
    int mismatched = 0;

    pulse_trigger_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .chan_en       (chan_en),
        .fifo_valid    (fifo_valid),
        .fifo_data     (fifo_data),
        .fifo_ready    (fifo_ready),
        .chan_req      (chan_req),
        .chan_done     (chan_done),
        .hdr_valid     (hdr_valid),
        .hdr_ready     (hdr_ready),
        .hdr_data      (hdr_data),
        .readout_done  (readout_done),
        .state         (state),
        .timeout_count (timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [127:0] d, input logic [4:0] en,
                                 input logic [4:0] done, input logic rdy);
        fifo_valid = v;
        fifo_data  = d;
        chan_en    = en;
        chan_done  = done;
        hdr_ready  = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] fifoWord(input logic [57:0] junk, input logic [1:0] len,
                                              input logic [23:0] num, input logic [43:0] ts);
        return {junk, len, num, ts};
    endfunction

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 128'h0, 5'b0, 5'b0, 1'b0);
        repeat (3) tick();

        checkOutput("rst_state",        state,         3'd0);
        checkOutput("rst_fifo_ready",   fifo_ready,    1'b0);
        checkOutput("rst_chan_req",     chan_req,      5'b0);
        checkOutput("rst_hdr_valid",    hdr_valid,     1'b0);
        checkOutput("rst_hdr_data",     hdr_data,      128'h0);
        checkOutput("rst_readout_done", readout_done,  1'b0);
        checkOutput("rst_timeout_cnt",  timeout_count, 32'd0);

        reset = 1'b0;
        hdr_ready = 1'b1;
        tick();
        checkOutput("post_rst_fifo_ready", fifo_ready, 1'b1);
        checkOutput("idle_hdr_ready_ignored", hdr_valid, 1'b0);

        // single event: channels 0 and 2, done three cycles after each request
        applyStimulus(1'b1, fifoWord(58'h0, 2'b10, 24'd7, 44'h123), 5'b00101, 5'b0, 1'b1);
        tick();
        checkOutput("t1_pick_state", state, 3'd1);
        checkOutput("t1_pick_fifo_ready", fifo_ready, 1'b0);
        applyStimulus(1'b0, 128'h0, 5'b0, 5'b0, 1'b1);
        tick();
        checkOutput("t1_req0", chan_req, 5'b00001);
        tick();
        checkOutput("t1_req0_one_cycle", chan_req, 5'b0);
        tick();
        tick();
        chan_done = 5'b00001;
        tick();
        chan_done = 5'b0;
        checkOutput("t1_pick2_state", state, 3'd1);
        tick();
        checkOutput("t1_req2", chan_req, 5'b00100);
        tick();
        tick();
        tick();
        chan_done = 5'b00100;
        tick();
        chan_done = 5'b0;
        checkOutput("t1_hdr_valid", hdr_valid, 1'b1);
        checkOutput("t1_hdr_data", hdr_data, {48'h0, 5'b00000, 5'b00101, 2'b10, 24'd7, 44'h123});
        checkOutput("t1_no_early_done", readout_done, 1'b0);
        tick();
        checkOutput("t1_readout_done", readout_done, 1'b1);
        checkOutput("t1_hdr_dropped", hdr_valid, 1'b0);
        tick();
        checkOutput("t1_done_once", readout_done, 1'b0);
        checkOutput("t1_back_idle", state, 3'd0);

        // timeout on channel 1; chan_en changes mid-event; ignored upper FIFO bits
        applyStimulus(1'b1, fifoWord(~58'h0, 2'b01, 24'hABCDEF, 44'h1), 5'b00010, 5'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 128'h0, 5'b11111, 5'b0, 1'b1);
        tick();
        checkOutput("t2_req1", chan_req, 5'b00010);
        for (int i = 1; i <= 16; i++) begin
            tick();
        end
        checkOutput("t2_still_wait_at_16", state, 3'd3);
        tick();
        checkOutput("t2_hdr_valid", hdr_valid, 1'b1);
        checkOutput("t2_hdr_data", hdr_data, {48'h0, 5'b00010, 5'b00010, 2'b01, 24'hABCDEF, 44'h1});
        checkOutput("t2_timeout_count", timeout_count, 32'd1);
        tick();
        checkOutput("t2_readout_done", readout_done, 1'b1);
        tick();

        // done collides with the timeout terminal count; other done bits ignored
        applyStimulus(1'b1, fifoWord(58'h0, 2'b00, 24'd3, 44'hFFFFFFFFFFF), 5'b00001, 5'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 128'h0, 5'b0, 5'b0, 1'b1);
        tick();
        checkOutput("t3_req0", chan_req, 5'b00001);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 5) begin
                chan_done = 5'b11110;
            end else if (i == 16) begin
                chan_done = 5'b00001;
            end else begin
                chan_done = 5'b0;
            end
        end
        checkOutput("t3_wait_before_collision", state, 3'd3);
        tick();
        chan_done = 5'b0;
        checkOutput("t3_hdr_valid", hdr_valid, 1'b1);
        checkOutput("t3_hdr_data", hdr_data, {48'h0, 5'b00000, 5'b00001, 2'b00, 24'd3, 44'hFFFFFFFFFFF});
        checkOutput("t3_timeout_unchanged", timeout_count, 32'd1);
        tick();
        tick();

        // no channels enabled
        applyStimulus(1'b1, fifoWord(58'h0, 2'b11, 24'd9, 44'd5), 5'b0, 5'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 128'h0, 5'b0, 5'b0, 1'b1);
        checkOutput("t4_state_send", state, 3'd4);
        checkOutput("t4_no_req", chan_req, 5'b0);
        checkOutput("t4_hdr_data", hdr_data, {48'h0, 5'b00000, 5'b00000, 2'b11, 24'd9, 44'd5});
        tick();
        checkOutput("t4_readout_done", readout_done, 1'b1);
        tick();
        checkOutput("t4_fifo_ready", fifo_ready, 1'b1);

        // backpressure with another FIFO word waiting
        applyStimulus(1'b1, fifoWord(58'h0, 2'b01, 24'd100, 44'h55), 5'b0, 5'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("t5_hdr_valid_held", hdr_valid, 1'b1);
            checkOutput("t5_hdr_data_held", hdr_data, {48'h0, 5'b00000, 5'b00000, 2'b01, 24'd100, 44'h55});
            checkOutput("t5_fifo_ready_low", fifo_ready, 1'b0);
            tick();
        end
        checkOutput("t5_no_second_pop", state, 3'd4);
        applyStimulus(1'b0, 128'h0, 5'b0, 5'b0, 1'b1);
        tick();
        checkOutput("t5_readout_done", readout_done, 1'b1);
        tick();
        checkOutput("t5_back_idle", state, 3'd0);

        // reset while waiting on channel 0
        applyStimulus(1'b1, fifoWord(58'h0, 2'b10, 24'd11, 44'h77), 5'b00011, 5'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 128'h0, 5'b0, 5'b0, 1'b1);
        tick();
        checkOutput("t6_req0", chan_req, 5'b00001);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("t6_rst_state",        state,         3'd0);
        checkOutput("t6_rst_fifo_ready",   fifo_ready,    1'b0);
        checkOutput("t6_rst_chan_req",     chan_req,      5'b0);
        checkOutput("t6_rst_hdr_valid",    hdr_valid,     1'b0);
        checkOutput("t6_rst_hdr_data",     hdr_data,      128'h0);
        checkOutput("t6_rst_readout_done", readout_done,  1'b0);
        checkOutput("t6_rst_timeout_cnt",  timeout_count, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("t6_fifo_ready_back", fifo_ready, 1'b1);
        checkOutput("t6_no_hdr", hdr_valid, 1'b0);
        checkOutput("t6_no_done", readout_done, 1'b0);

        applyStimulus(1'b1, fifoWord(58'h0, 2'b01, 24'd12, 44'h88), 5'b00100, 5'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 128'h0, 5'b0, 5'b0, 1'b1);
        tick();
        checkOutput("t6_req2", chan_req, 5'b00100);
        tick();
        tick();
        chan_done = 5'b00100;
        tick();
        chan_done = 5'b0;
        checkOutput("t6_hdr_valid", hdr_valid, 1'b1);
        checkOutput("t6_hdr_data", hdr_data, {48'h0, 5'b00000, 5'b00100, 2'b01, 24'd12, 44'h88});
        tick();
        checkOutput("t6_readout_done", readout_done, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pulse_trigger_sequencer.md
# pulse_trigger_sequencer

Consumer side of the Pulse Trigger FIFO. Pops one 128-bit trigger-info word at a time, then requests a readout from each enabled channel in ascending order and waits for each channel's done, with a timeout. It emits one 128-bit trigger header to the downstream event builder and pulses `readout_done` back to the trigger receiver when the event is complete.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: cycles to wait for a channel done before declaring a timeout. Legal range 2..65535.

Ports:
- `clk`  in  1  40 MHz TTC clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `chan_en`  in  5  enabled channels; sampled at FIFO pop.
- `fifo_valid`  in  1  Pulse Trigger FIFO word available.
- `fifo_data`  in  128  trigger info: [69:68] length, [67:44] trig_num, [43:0] timestamp; [127:70] ignored.
- `fifo_ready`  out  1  pop strobe; a transfer occurs when `fifo_valid & fifo_ready`.
- `chan_req`  out  5  one-cycle readout request, one-hot.
- `chan_done`  in  5  per-channel readout-complete pulse.
- `hdr_valid`  out  1  header word valid.
- `hdr_ready`  in  1  downstream accepts header.
- `hdr_data`  out  128  header word; layout in Operation.
- `readout_done`  out  1  one-cycle pulse when the event is finished.
- `state`  out  3  current FSM state, for status.
- `timeout_count`  out  32  cumulative channel timeouts, saturating.

## Operation
State machine:
- IDLE:
  - `fifo_ready=1`.
  - On transfer: latch length, trig_num and timestamp; snapshot `chan_en` into `pend` and `mask`; clear `to_mask`.
  - If `chan_en==0`, go to SEND_HDR; otherwise go to PICK.
- PICK:
  - `idx` = lowest set bit of `pend`.
  - Clear the timeout counter; go to REQ.
- REQ: assert `chan_req[idx]` for exactly one cycle; go to WAIT.
- WAIT:
  - If `chan_done[idx]`: clear `pend[idx]`.
  - Else, when the counter reaches TIMEOUT_CYCLES-1: set `to_mask[idx]`, increment `timeout_count` (saturating at 2^32-1), clear `pend[idx]`.
  - In either case, next state is SEND_HDR if `pend` is then zero, else PICK.
  - `chan_done` bits other than `idx` are ignored in every state.
- SEND_HDR:
  - `hdr_valid=1`, with `hdr_data` held stable until the handshake.
  - When `hdr_ready` is high, go to DONE.
- DONE: `readout_done=1` for one cycle; go to IDLE.

Header layout (`hdr_data`):
- [127:80] zero
- [79:75] `to_mask`
- [74:70] `mask`
- [69:68] length
- [67:44] trig_num
- [43:0] timestamp

Boundary behaviour:
- `chan_done[idx]` and the timeout terminal count in the same cycle: done wins; no timeout is recorded.
- `chan_en` changes mid-event: no effect on the current event.
- `hdr_ready` held high while idle: ignored.
- A length field of 2'b00 is passed through unchanged.
- Reset mid-event: everything returns to reset values and the in-flight event is dropped. No header and no `readout_done` are emitted. The FIFO word is not re-read.

## Timing
Reset values:
- `fifo_ready=0`, `chan_req=0`, `hdr_valid=0`, `hdr_data=0`, `readout_done=0`, `timeout_count=0`, `state`=IDLE.
- `fifo_ready` rises the cycle after reset deasserts.

Latencies:
- Pop to first `chan_req`: 2 cycles (pop in cycle N, PICK at N+1, REQ at N+2).
- Done to next `chan_req`: 2 cycles.
- Done of the last channel to `hdr_valid`: 1 cycle.
- `hdr_ready` accepted to `readout_done`: 1 cycle.

Timeout:
- Counted from the first WAIT cycle; fires on the TIMEOUT_CYCLES-th WAIT cycle.

Throughput and output style:
- At most one event in flight; `fifo_ready` is low outside IDLE.
- All outputs are registered except `fifo_ready`, which is decoded from `state`.

## Structure
Shared package `pulse_trigger_pkg`:
- trigger-info field offsets and widths: LEN_LSB=68, NUM_LSB=44, TS_WIDTH=44;
- header field offsets;
- `NUM_CHAN=5`;
- state encodings IDLE/PICK/REQ/WAIT/SEND_HDR/DONE.

The receiver must use the same package for its FIFO packing.

One sub-module, `chan_priority_pick`: combinational lowest-set-bit encoder, 5-bit mask to 3-bit index plus a `none` flag. Everything else lives in a single FSM plus datapath.

## Test plan
- **Single event:** `chan_en`=5'b00101; FIFO word {len=2'b10, num=7, ts=0x123}; each done returned 3 cycles after its req.
  - `chan_req` sequence is 5'b00001 then 5'b00100.
  - `hdr_data[79:0]` = {5'b0, 5'b00101, 2'b10, 24'd7, 44'h123}.
  - `readout_done` pulses once.
- **Timeout:** TIMEOUT_CYCLES=16; `chan_en`=5'b00010; no done.
  - `chan_req[1]` fires; after 16 WAIT cycles, header `to_mask`=5'b00010.
  - `timeout_count`=1.
- **Done/timeout collision:** `chan_done[idx]` lands on cycle TIMEOUT_CYCLES of WAIT → `to_mask`=0 and `timeout_count` unchanged.
- **No channels enabled:** `chan_en`=0 → no `chan_req`; header has `mask`=0; `readout_done` fires 2 cycles after the pop.
- **Backpressure:** hold `hdr_ready` low for 10 cycles → `hdr_valid` and `hdr_data` stay stable; `fifo_ready` stays 0; no second pop.
- **Reset mid-event:** assert `reset` in WAIT → next cycle all outputs are at reset values; no header and no `readout_done`; the next FIFO word is processed normally.
